multicycle_controller: RTL and testbench

Control unit for the multicycle RV32I core (lw, sw, R-type, I-type ALU, beq, jal). It sits beside the multicycle datapath and shares a single instruction/data memory between fetch and load/store. The block sequences every instruction through a Moore FSM, decodes ALU operations and immediate formats, and stalls on a memory-ready handshake. All datapath write enables come from this block.

---
 rtl/riscv_pkg.sv | 69 ++++++
 rtl/alu_decoder.sv | 37 +++
 rtl/multicycle_controller.sv | 158 +++++++++++++++
 tb/tb_multicycle_controller.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared encodings for the multicycle RV32I core.
// Holds opcode constants, FSM state encodings, ALUControl codes, ALUOp codes,
// ImmSrc codes and the ResultSrc / ALUSrcA / ALUSrcB mux selects. The
// controller and the datapath both import it, so each encoding is defined once.
package riscv_pkg;

   // Supported opcodes (Instr[6:0])
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_RTYPE = 7'b0110011;
   localparam logic [6:0] OP_ITYPE = 7'b0010011;
   localparam logic [6:0] OP_BEQ   = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;

   // Controller states; codes 11-15 are unused and recover to Fetch
   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTER = 4'd6,
      S_EXECUTEI = 4'd7,
      S_ALUWB    = 4'd8,
      S_BEQ      = 4'd9,
      S_JAL      = 4'd10
   } state_t;

   // ALUControl codes
   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   // ALUOp: what the FSM asks the ALU decoder for
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   // Immediate formats
   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

   // ResultSrc selects
   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   // ALUSrcA selects
   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;

   // ALUSrcB selects
   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   // True for the six opcodes the core executes
   function automatic logic op_supported(input logic [6:0] op);
      return (op == OP_LOAD)  || (op == OP_STORE) || (op == OP_RTYPE) ||
             (op == OP_ITYPE) || (op == OP_BEQ)   || (op == OP_JAL);
   endfunction

endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: turns the FSM's ALUOp plus instruction fields into ALUControl.
// Ports:
//   ALUOp      in  2  00 add, 01 sub, 10 decode from funct3/funct7b5
//   funct3     in  3  Instr[14:12]
//   op5        in  1  Instr[5]; distinguishes R-type (sub allowed) from I-type
//   funct7b5   in  1  Instr[30]
//   ALUControl out 3  ALU operation code
module alu_decoder
   import riscv_pkg::*;
(
   input  logic [1:0] ALUOp,
   input  logic [2:0] funct3,
   input  logic       op5,
   input  logic       funct7b5,
   output logic [2:0] ALUControl
);

   always_comb begin
      ALUControl = ALU_ADD;
      case (ALUOp)
         ALUOP_ADD: ALUControl = ALU_ADD;
         ALUOP_SUB: ALUControl = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct3)
               // addi has no sub form: Instr[30] is immediate data there
               3'b000:  ALUControl = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
               3'b010:  ALUControl = ALU_SLT;
               3'b110:  ALUControl = ALU_OR;
               3'b111:  ALUControl = ALU_AND;
               default: ALUControl = ALU_ADD;
            endcase
         end
         default: ALUControl = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore-FSM control unit for the multicycle RV32I core
// (lw, sw, R-type, I-type ALU, beq, jal) with a shared instruction/data memory.
// Ports:
//   clk, reset (async, active-low)
//   op, funct3, funct7b5  instruction fields from the instruction register
//   zero                  ALU zero flag (beq)
//   MemReady              memory finishes the current access this cycle
//   PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
//   ALUControl, ImmSrc, RegWrite   datapath controls
//   Illegal               one-cycle pulse in Decode for an unsupported opcode
//   state                 current FSM state (debug)
// All outputs are combinational from the current state and inputs.
module multicycle_controller
   import riscv_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       zero,
   input  logic       MemReady,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [2:0] ALUControl,
   output logic [1:0] ImmSrc,
   output logic       RegWrite,
   output logic       Illegal,
   output logic [3:0] state
);

   state_t     r_state;
   logic [1:0] w_alu_op;
   logic       w_branch;
   logic       w_pc_update;
   logic       w_ir_write;
   logic       w_mem_write;
   logic       w_reg_write;

   // State register; reset assertion takes effect immediately
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_FETCH;
      end else begin
         case (r_state)
            S_FETCH:    if (MemReady) r_state <= S_DECODE;
            S_DECODE: begin
               case (op)
                  OP_LOAD, OP_STORE: r_state <= S_MEMADR;
                  OP_RTYPE:          r_state <= S_EXECUTER;
                  OP_ITYPE:          r_state <= S_EXECUTEI;
                  OP_BEQ:            r_state <= S_BEQ;
                  OP_JAL:            r_state <= S_JAL;
                  default:           r_state <= S_FETCH;  // illegal: nop
               endcase
            end
            S_MEMADR:   r_state <= (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (MemReady) r_state <= S_MEMWB;
            S_MEMWRITE: if (MemReady) r_state <= S_FETCH;
            S_EXECUTER, S_EXECUTEI, S_JAL: r_state <= S_ALUWB;
            // MemWB, ALUWB, BEQ and the unused codes all return to Fetch
            default:    r_state <= S_FETCH;
         endcase
      end
   end

   // Moore outputs; Fetch additionally follows MemReady so IR/PC only
   // load when the instruction word is actually on the bus
   always_comb begin
      AdrSrc      = 1'b0;
      ResultSrc   = RES_ALUOUT;
      ALUSrcA     = SRCA_PC;
      ALUSrcB     = SRCB_RS2;
      w_alu_op    = ALUOP_ADD;
      w_branch    = 1'b0;
      w_pc_update = 1'b0;
      w_ir_write  = 1'b0;
      w_mem_write = 1'b0;
      w_reg_write = 1'b0;
      case (r_state)
         S_FETCH: begin
            w_ir_write  = MemReady;
            w_pc_update = MemReady;
            ALUSrcB     = SRCB_FOUR;
            ResultSrc   = RES_ALURESULT;
         end
         S_DECODE: begin
            ALUSrcA = SRCA_OLDPC;
            ALUSrcB = SRCB_IMM;
         end
         S_MEMADR: begin
            ALUSrcA = SRCA_RS1;
            ALUSrcB = SRCB_IMM;
         end
         S_MEMREAD:  AdrSrc = 1'b1;
         S_MEMWB: begin
            ResultSrc   = RES_DATA;
            w_reg_write = 1'b1;
         end
         S_MEMWRITE: begin
            AdrSrc      = 1'b1;
            w_mem_write = 1'b1;
         end
         S_EXECUTER: begin
            ALUSrcA  = SRCA_RS1;
            w_alu_op = ALUOP_FUNCT;
         end
         S_EXECUTEI: begin
            ALUSrcA  = SRCA_RS1;
            ALUSrcB  = SRCB_IMM;
            w_alu_op = ALUOP_FUNCT;
         end
         S_ALUWB:    w_reg_write = 1'b1;
         S_BEQ: begin
            ALUSrcA  = SRCA_RS1;
            w_alu_op = ALUOP_SUB;
            w_branch = 1'b1;
         end
         S_JAL: begin
            ALUSrcA     = SRCA_OLDPC;
            ALUSrcB     = SRCB_FOUR;
            w_pc_update = 1'b1;
         end
         default: ;
      endcase
   end

   // Write enables are gated by reset so none leaks while reset is low
   assign PCWrite  = reset & (w_pc_update | (w_branch & zero));
   assign IRWrite  = reset & w_ir_write;
   assign MemWrite = reset & w_mem_write;
   assign RegWrite = reset & w_reg_write;
   assign Illegal  = reset & (r_state == S_DECODE) & ~op_supported(op);
   assign state    = r_state;

   always_comb begin
      case (op)
         OP_STORE: ImmSrc = IMM_S;
         OP_BEQ:   ImmSrc = IMM_B;
         OP_JAL:   ImmSrc = IMM_J;
         default:  ImmSrc = IMM_I;
      endcase
   end

   alu_decoder u_alu_decoder (
      .ALUOp      (w_alu_op),
      .funct3     (funct3),
      .op5        (op[5]),
      .funct7b5   (funct7b5),
      .ALUControl (ALUControl)
   );

endmodule

// File: tb/tb_multicycle_controller.sv
`timescale 1ps/1ps
module tb_multicycle_controller;
   import riscv_pkg::*;

   logic       clk;
   logic       reset;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7b5;
   logic       zero;
   logic       MemReady;
   logic       PCWrite;
   logic       AdrSrc;
   logic       MemWrite;
   logic       IRWrite;
   logic [1:0] ResultSrc;
   logic [1:0] ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [2:0] ALUControl;
   logic [1:0] ImmSrc;
   logic       RegWrite;
   logic       Illegal;
   logic [3:0] state;

   int checks = 0;
   int errors = 0;

   // Operand selects required in each state (indexed by state number)
   int srca_tab [11] = '{0, 1, 2, 0, 0, 0, 2, 2, 0, 2, 1};
   int srcb_tab [11] = '{2, 1, 1, 0, 0, 0, 0, 1, 0, 0, 2};

   multicycle_controller dut (
      .clk        (clk),
      .reset      (reset),
      .op         (op),
      .funct3     (funct3),
      .funct7b5   (funct7b5),
      .zero       (zero),
      .MemReady   (MemReady),
      .PCWrite    (PCWrite),
      .AdrSrc     (AdrSrc),
      .MemWrite   (MemWrite),
      .IRWrite    (IRWrite),
      .ResultSrc  (ResultSrc),
      .ALUSrcA    (ALUSrcA),
      .ALUSrcB    (ALUSrcB),
      .ALUControl (ALUControl),
      .ImmSrc     (ImmSrc),
      .RegWrite   (RegWrite),
      .Illegal    (Illegal),
      .state      (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic is_legal(input logic [6:0] o);
      return (o == OP_LOAD) || (o == OP_STORE) || (o == OP_RTYPE) ||
             (o == OP_ITYPE) || (o == OP_BEQ) || (o == OP_JAL);
   endfunction

   // ALU operation the instruction asks for (cls: 2 R-type, 3 I-type, 4 beq)
   function automatic logic [2:0] alu_ref(input int cls, input logic [2:0] f3, input logic f7);
      if (cls == 4) return 3'b001;
      case (f3)
         3'b000:  return (cls == 2 && f7) ? 3'b001 : 3'b000;
         3'b010:  return 3'b101;
         3'b110:  return 3'b011;
         3'b111:  return 3'b010;
         default: return 3'b000;
      endcase
   endfunction

   task automatic test_reset();
      #3;
      checks++; if (state !== 4'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", state); end
      checks++; if ({PCWrite, IRWrite, MemWrite, RegWrite, Illegal} !== 5'b0) begin
         errors++; $display("FAIL reset_enables got=%b exp=00000", {PCWrite, IRWrite, MemWrite, RegWrite, Illegal});
      end
      checks++; if ({ResultSrc, ALUSrcA, ALUSrcB} !== 6'b10_00_10) begin
         errors++; $display("FAIL reset_fetch_sel got=%b exp=100010", {ResultSrc, ALUSrcA, ALUSrcB});
      end
      #19 reset = 1'b1;   // released at 22 ps
      $display("reset released at %0t", $time);
   endtask

   task automatic test_lw();
      int seq [6] = '{0, 1, 2, 3, 4, 0};
      #1;
      checks++; if (state !== 4'd0) begin errors++; $display("FAIL lw_start got=%0d exp=0", state); end
      for (int i = 1; i < 6; i++) begin
         tick();
         checks++; if (state !== 4'(seq[i])) begin errors++; $display("FAIL lw_state step=%0d got=%0d exp=%0d", i, state, seq[i]); end
         checks++; if (RegWrite !== (seq[i] == 4)) begin errors++; $display("FAIL lw_regwrite step=%0d got=%b exp=%b", i, RegWrite, seq[i] == 4); end
         checks++; if (AdrSrc !== (seq[i] == 3)) begin errors++; $display("FAIL lw_adrsrc step=%0d got=%b exp=%b", i, AdrSrc, seq[i] == 3); end
      end
      $display("lw done");
   endtask

   task automatic test_sw_stall();
      op = OP_STORE;
      #1;
      checks++; if (ImmSrc !== 2'b01) begin errors++; $display("FAIL sw_immsrc got=%b exp=01", ImmSrc); end
      tick(); tick(); tick();
      checks++; if (state !== 4'd5) begin errors++; $display("FAIL sw_enter got=%0d exp=5", state); end
      for (int k = 0; k < 3; k++) begin
         MemReady = (k == 2);
         #1;
         checks++; if (MemWrite !== 1'b1 || state !== 4'd5) begin
            errors++; $display("FAIL sw_hold k=%0d memwrite=%b state=%0d exp 1/5", k, MemWrite, state);
         end
         tick();
      end
      checks++; if (state !== 4'd0 || MemWrite !== 1'b0) begin
         errors++; $display("FAIL sw_exit state=%0d memwrite=%b exp 0/0", state, MemWrite);
      end
      $display("sw with 2 stall cycles done");
   endtask

   task automatic test_alu_decode();
      op = OP_RTYPE; funct3 = 3'b000; funct7b5 = 1'b1;
      tick(); tick();
      checks++; if (state !== 4'd6 || ALUControl !== 3'b001) begin
         errors++; $display("FAIL rtype_sub state=%0d aluctl=%b exp 6/001", state, ALUControl);
      end
      tick();
      checks++; if (state !== 4'd8 || RegWrite !== 1'b1) begin
         errors++; $display("FAIL rtype_wb state=%0d regwrite=%b exp 8/1", state, RegWrite);
      end
      tick();
      op = OP_ITYPE;
      tick(); tick();
      checks++; if (state !== 4'd7 || ALUControl !== 3'b000) begin
         errors++; $display("FAIL addi state=%0d aluctl=%b exp 7/000", state, ALUControl);
      end
      tick(); tick();
      checks++; if (state !== 4'd0) begin errors++; $display("FAIL addi_exit got=%0d exp=0", state); end
      $display("sub / addi decode done");
   endtask

   task automatic test_beq();
      for (int z = 1; z >= 0; z--) begin
         op = OP_BEQ; zero = 1'(z);
         tick(); tick();
         checks++; if (state !== 4'd9 || PCWrite !== 1'(z)) begin
            errors++; $display("FAIL beq_pcwrite zero=%0d state=%0d pcwrite=%b exp 9/%0d", z, state, PCWrite, z);
         end
         tick();
         checks++; if (state !== 4'd0) begin errors++; $display("FAIL beq_exit zero=%0d got=%0d exp=0", z, state); end
         $display("beq zero=%0d done", z);
      end
   endtask

   task automatic test_illegal();
      op = 7'h7F;
      tick();
      checks++; if (state !== 4'd1 || Illegal !== 1'b1) begin
         errors++; $display("FAIL illegal_pulse state=%0d illegal=%b exp 1/1", state, Illegal);
      end
      checks++; if ({PCWrite, IRWrite, MemWrite, RegWrite} !== 4'b0) begin
         errors++; $display("FAIL illegal_enables got=%b exp=0000", {PCWrite, IRWrite, MemWrite, RegWrite});
      end
      tick();
      checks++; if (state !== 4'd0 || Illegal !== 1'b0) begin
         errors++; $display("FAIL illegal_exit state=%0d illegal=%b exp 0/0", state, Illegal);
      end
      $display("illegal opcode done");
   endtask

   task automatic test_reset_mid();
      op = OP_LOAD;
      tick(); tick(); tick(); tick();
      checks++; if (state !== 4'd4 || RegWrite !== 1'b1) begin
         errors++; $display("FAIL mid_memwb state=%0d regwrite=%b exp 4/1", state, RegWrite);
      end
      reset = 1'b0;
      #1;
      checks++; if (state !== 4'd0 || RegWrite !== 1'b0) begin
         errors++; $display("FAIL mid_abort state=%0d regwrite=%b exp 0/0", state, RegWrite);
      end
      checks++; if ({PCWrite, IRWrite, MemWrite} !== 3'b0) begin
         errors++; $display("FAIL mid_enables got=%b exp=000", {PCWrite, IRWrite, MemWrite});
      end
      MemReady = 1'b0;
      #1 reset = 1'b1;
      tick();
      checks++; if (state !== 4'd0) begin errors++; $display("FAIL mid_recover got=%0d exp=0", state); end
      $display("reset during MemWB done");
   endtask

   // Random instruction mix with random memory stalls. The model walks each
   // instruction's state path; Fetch, MemRead and MemWrite wait for MemReady.
   task automatic test_random();
      int          path[$];
      int          cls, idx, stalls, s, cycles;
      logic [6:0]  o;
      logic [2:0]  f3;
      logic        f7, mr, z;
      logic [20:0] act, exp;
      logic        e_pcw, e_irw, e_mw, e_rw, e_adr, e_ill;
      logic [1:0]  e_res, e_imm;
      logic [2:0]  e_alu;
      for (int n = 0; n < 80; n++) begin
         cls = $urandom_range(0, 6);
         f3  = 3'($urandom);
         f7  = 1'($urandom);
         case (cls)
            0: begin o = OP_LOAD;  path = '{0, 1, 2, 3, 4};  e_imm = 2'b00; end
            1: begin o = OP_STORE; path = '{0, 1, 2, 5};     e_imm = 2'b01; end
            2: begin o = OP_RTYPE; path = '{0, 1, 6, 8};     e_imm = 2'b00; end
            3: begin o = OP_ITYPE; path = '{0, 1, 7, 8};     e_imm = 2'b00; end
            4: begin o = OP_BEQ;   path = '{0, 1, 9};        e_imm = 2'b10; end
            5: begin o = OP_JAL;   path = '{0, 1, 10, 8};    e_imm = 2'b11; end
            default: begin
               o = 7'($urandom);
               for (int t = 0; t < 16 && is_legal(o); t++) o = 7'($urandom);
               if (is_legal(o)) o = 7'h7F;
               path = '{0, 1}; e_imm = 2'b00;
            end
         endcase
         op = o; funct3 = f3; funct7b5 = f7;
         idx = 0; stalls = 0; cycles = 0;
         for (int cyc = 0; cyc < 40 && idx < path.size(); cyc++) begin
            mr = (stalls >= 3) ? 1'b1 : ($urandom_range(0, 3) != 0);
            z  = 1'($urandom);
            MemReady = mr; zero = z;
            #1;
            s     = path[idx];
            e_irw = (idx == 0) && mr;
            e_pcw = e_irw || (idx == 2 && (cls == 5 || (cls == 4 && z)));
            e_mw  = (cls == 1 && idx == 3);
            e_rw  = (cls == 0 && idx == 4) || ((cls == 2 || cls == 3 || cls == 5) && idx == 3);
            e_adr = (cls <= 1 && idx == 3);
            e_ill = (cls == 6 && idx == 1);
            e_res = (s == 0) ? 2'b10 : (s == 4) ? 2'b01 : 2'b00;
            e_alu = (idx == 2 && cls >= 2 && cls <= 4) ? alu_ref(cls, f3, f7) : 3'b000;
            exp = {4'(s), e_pcw, e_irw, e_mw, e_rw, e_adr, e_ill, e_res,
                   2'(srca_tab[s]), 2'(srcb_tab[s]), e_alu, e_imm};
            act = {state, PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, Illegal, ResultSrc,
                   ALUSrcA, ALUSrcB, ALUControl, ImmSrc};
            checks++;
            if (act !== exp) begin
               errors++;
               $display("FAIL random n=%0d cls=%0d op=%b step=%0d got=%h exp=%h", n, cls, o, idx, act, exp);
            end
            if ((s == 0 || s == 3 || s == 5) && !mr) stalls++;
            else begin idx++; stalls = 0; end
            cycles++;
            tick();
         end
         checks++;
         if (idx < path.size()) begin
            errors++;
            $display("FAIL random_timeout n=%0d cls=%0d step=%0d exp=%0d", n, cls, idx, path.size());
         end
         $display("instr %0d cls=%0d op=%b f3=%b f7=%b cycles=%0d", n, cls, o, f3, f7, cycles);
      end
   endtask

   initial begin
      reset = 1'b0; MemReady = 1'b1; op = OP_LOAD;
      funct3 = 3'b000; funct7b5 = 1'b0; zero = 1'b0;
      test_reset();
      test_lw();
      test_sw_stall();
      test_alu_decode();
      test_beq();
      test_illegal();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
